// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, occupancy values and default control-field layout
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE = 2'd1;
   localparam logic [1:0] OCC_TWO = 2'd2;
   localparam int TARGET_REG_W = 3;
   localparam int FUNCT_W = 5;
   localparam int REGWRITE_IDX = TARGET_REG_W + FUNCT_W;
   localparam int CTRL_W_DEF = REGWRITE_IDX + 1;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one payload+control storage register with load and clear (clear wins)
module pipe_entry #(
   parameter int W = 41
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;
   // reset and clear zero the entry; otherwise capture on load
   always_ff @(posedge clk)
      q_q <= (reset | clear_i) ? '0 : load_i ? d_i : q_q;
   assign q_o = q_q;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline boundary with a 2-entry skid buffer and synchronous flush.
// Optional macro PIPE_SKID_ZERO_ON_FLUSH_EN: flush and drain-to-empty also zero the data entries.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 9,
   parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);
   localparam int W = DATA_W + CTRL_W;
   state_e state_q, state_d;
   logic in_ready_q, out_valid_q;
   logic in_fire, out_fire, take, main_load, skid_load, clr;
   logic [W-1:0] main_d, main_q, skid_q;
   assign in_fire = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;
   // a beat offered during flush is discarded even though in_ready is high
   assign take = in_fire & ~flush;
   // next state: flush forces EMPTY, otherwise follow the handshake
   always_comb
      state_d = flush ? EMPTY :
                state_q == EMPTY ? (take ? ONE : EMPTY) :
                state_q == ONE ? ((take & ~out_fire) ? TWO : (~take & out_fire) ? EMPTY : ONE) :
                out_fire ? ONE : TWO;
   // state plus ready/valid registered from the next state so no combinational ready path exists
   always_ff @(posedge clk)
      if (reset) begin
         state_q <= EMPTY;
         in_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         in_ready_q <= state_d != TWO;
         out_valid_q <= state_d != EMPTY;
      end
   assign main_load = take & (state_q == EMPTY | (state_q == ONE & out_fire)) | (~flush & state_q == TWO & out_fire);
   assign main_d = state_q == TWO ? skid_q : {in_data, in_ctrl};
   assign skid_load = take & state_q == ONE & ~out_fire;
`ifdef PIPE_SKID_ZERO_ON_FLUSH_EN
   assign clr = flush | (state_q == ONE & ~take & out_fire);
`else
   assign clr = 1'b0;
`endif
   pipe_entry #(.W(W)) u_main (
      .clk(clk), .reset(reset), .clear_i(clr), .load_i(main_load), .d_i(main_d), .q_o(main_q)
   );
   pipe_entry #(.W(W)) u_skid (
      .clk(clk), .reset(reset), .clear_i(clr), .load_i(skid_load), .d_i({in_data, in_ctrl}), .q_o(skid_q)
   );
   assign in_ready = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data = main_q[W-1:CTRL_W];
   // a stale regWrite must never leave the stage while no beat is valid
   assign out_ctrl = out_valid_q ? main_q[CTRL_W-1:0] : CTRL_RST;
   assign occupancy = state_q == TWO ? OCC_TWO : state_q == ONE ? OCC_ONE : OCC_EMPTY;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random-handshake checks of pipe_skid_stage against a queue model
module tb_pipe_skid_stage;
   import pipe_pkg::*;
   logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_data = '0;
   logic [8:0] in_ctrl = '0;
   logic in_ready, out_valid;
   logic [31:0] out_data;
   logic [8:0] out_ctrl;
   logic [1:0] occupancy;
   int checks = 0, failures = 0;
   logic [40:0] mq[$];
   logic [40:0] ent;
   logic m_in_rdy, m_out_vld;
   pipe_skid_stage dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_state(input string tag, input logic v, input logic r, input logic [1:0] occ);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(r));
      chk({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
   endtask
   initial begin
      tick();
      tick();
      chk_state("reset", 0, 1, 0);
      chk("reset.out_data", 64'(out_data), 0);
      chk("reset.out_ctrl", 64'(out_ctrl), 0);
      reset = 0;
      in_valid = 1; in_data = 32'hA5; in_ctrl = 9'h1AB; out_ready = 1;
      tick();
      chk_state("first", 1, 1, 1);
      chk("first.out_data", 64'(out_data), 64'hA5);
      chk("first.out_ctrl", 64'(out_ctrl), 64'h1AB);
      for (int i = 1; i <= 8; i++) begin
         in_data = 32'(i); in_ctrl = 9'(i);
         tick();
         chk_state("stream", 1, 1, 1);
         chk("stream.out_data", 64'(out_data), 64'(i));
         chk("stream.out_ctrl", 64'(out_ctrl), 64'(i));
      end
      in_valid = 0;
      tick();
      chk_state("drain", 0, 1, 0);
      chk("drain.out_ctrl", 64'(out_ctrl), 0);
      out_ready = 0; in_valid = 1; in_data = 32'h11; in_ctrl = 9'h011;
      tick();
      chk_state("bp1", 1, 1, 1);
      in_data = 32'h22; in_ctrl = 9'h022;
      tick();
      chk_state("bp2", 1, 0, 2);
      chk("bp2.out_data", 64'(out_data), 64'h11);
      in_data = 32'h33; in_ctrl = 9'h033;
      tick();
      chk_state("bp_hold", 1, 0, 2);
      chk("bp_hold.out_data", 64'(out_data), 64'h11);
      out_ready = 1;
      tick();
      chk_state("bp_rel1", 1, 1, 1);
      chk("bp_rel1.out_data", 64'(out_data), 64'h22);
      chk("bp_rel1.out_ctrl", 64'(out_ctrl), 64'h022);
      tick();
      chk_state("bp_rel2", 1, 1, 1);
      chk("bp_rel2.out_data", 64'(out_data), 64'h33);
      in_valid = 0;
      tick();
      chk_state("bp_empty", 0, 1, 0);
      out_ready = 0; in_valid = 1; in_data = 32'h55; in_ctrl = 9'h1FF;
      tick();
      in_data = 32'h66;
      tick();
      chk_state("pre_flush", 1, 0, 2);
      in_data = 32'h44; flush = 1;
      tick();
      chk_state("flush", 0, 1, 0);
      chk("flush.out_ctrl", 64'(out_ctrl), 0);
`ifdef PIPE_SKID_ZERO_ON_FLUSH_EN
      chk("flush.out_data", 64'(out_data), 0);
`endif
      flush = 0; in_valid = 0; out_ready = 1;
      tick();
      chk_state("post_flush", 0, 1, 0);
      in_valid = 1; in_data = 32'h77; in_ctrl = 9'h1FF;
      tick();
      chk("pre_rst.regwrite", 64'(out_ctrl[REGWRITE_IDX]), 1);
      reset = 1; in_valid = 0;
      tick();
      chk_state("mid_rst", 0, 1, 0);
      chk("mid_rst.out_ctrl", 64'(out_ctrl), 0);
      chk("mid_rst.regwrite", 64'(out_ctrl[REGWRITE_IDX]), 0);
      chk("mid_rst.out_data", 64'(out_data), 0);
      reset = 0; out_ready = 0; in_valid = 1; in_data = 32'h88; in_ctrl = 9'h008;
      tick();
      in_data = 32'h99; in_ctrl = 9'h009;
      tick();
      in_data = 'x; in_ctrl = 'x;
      tick();
      chk_state("xdata", 1, 0, 2);
      chk("xdata.out_data", 64'(out_data), 64'h88);
      in_valid = 0; out_ready = 1;
      tick();
      chk("xdrain.out_data", 64'(out_data), 64'h99);
      tick();
      chk_state("xdrain_empty", 0, 1, 0);
      for (int c = 0; c < 100; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data = $urandom;
         in_ctrl = 9'($urandom);
         m_in_rdy = mq.size() != 2;
         m_out_vld = mq.size() != 0;
         chk_state("rand", m_out_vld, m_in_rdy, 2'(mq.size()));
         if (m_out_vld) begin
            ent = mq[0];
            chk("rand.out_data", 64'(out_data), 64'(ent[40:9]));
            chk("rand.out_ctrl", 64'(out_ctrl), 64'(ent[8:0]));
         end else
            chk("rand.out_ctrl_idle", 64'(out_ctrl), 0);
         if (m_out_vld && out_ready) void'(mq.pop_front());
         if (in_valid && m_in_rdy) mq.push_back({in_data, in_ctrl});
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
